// File: rtl/led_matrix_scanner.sv
// Time-multiplexed scan driver for N_DISP LED matrices sharing one active-low row bus.
// Double-buffered frame store, swap at frame boundary, dwell/blank timing and 16-level PWM.
module led_matrix_scanner #(
    parameter int N_DISP = 2,
    parameter int N_COLS = 8,
    parameter int N_ROWS = 8,
    parameter int DWELL  = 16384,
    parameter int BLANK  = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       wr_en,
    input  logic [((N_DISP > 1) ? $clog2(N_DISP) : 1)-1:0] wr_disp,
    input  logic [$clog2(N_COLS)-1:0]                  wr_col,
    input  logic [N_ROWS-1:0]                          wr_data,
    input  logic                                       swap_req,
    input  logic [3:0]                                 bright,
    output logic [N_DISP*N_COLS-1:0]                   col_en,
    output logic [N_ROWS-1:0]                          row_n,
    output logic                                       swap_ack,
    output logic                                       frame_start
);
    localparam int DISP_W = (N_DISP > 1) ? $clog2(N_DISP) : 1;
    localparam int COL_W  = $clog2(N_COLS);
    localparam int NSLOT  = N_DISP * N_COLS;
    localparam int CNT_W  = $clog2((DWELL > BLANK) ? DWELL : BLANK) + 1;
    localparam int SEG    = DWELL / 16;

    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [DISP_W-1:0] DISP_LAST  = DISP_W'(N_DISP - 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(N_COLS - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CNT_W-1:0]    lit_len, lit_n;
    logic [COL_W-1:0]    col, col_n;
    logic [DISP_W-1:0]   disp, disp_n;
    logic                front, pending, fs_q, first;
    logic                active, boundary, do_swap, wr_ok;
    logic [31:0]         slot_idx;
    logic [NSLOT-1:0]    col_en_n;
    logic [N_ROWS-1:0]   fb [2][N_DISP][N_COLS];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        lit_n    = lit_len;
        col_n    = col;
        disp_n   = disp;
        active   = 1'b0;
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_n   = '0;
                    lit_n   = CNT_W'((32'(bright) + 32'd1) * 32'(SEG));
                    state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                active = (cnt < lit_len);
                if (cnt == DWELL_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_BLANK;
                    // display index advances fastest, column wraps mark the frame end
                    if (disp == DISP_LAST) begin
                        disp_n = '0;
                        if (col == COL_LAST) begin
                            col_n    = '0;
                            boundary = 1'b1;
                        end else begin
                            col_n = col + 1'b1;
                        end
                    end else begin
                        disp_n = disp + 1'b1;
                    end
                end
            end
            default: state_n = ST_BLANK;
        endcase
    end

    assign do_swap  = boundary && (pending || swap_req);
    assign slot_idx = 32'(disp) * 32'(N_COLS) + 32'(col);
    assign col_en_n = active ? (NSLOT'(1) << slot_idx) : '0;
    assign wr_ok    = (32'(wr_disp) < 32'(N_DISP)) && (32'(wr_col) < 32'(N_COLS));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            lit_len  <= '0;
            col      <= '0;
            disp     <= '0;
            front    <= 1'b0;
            pending  <= 1'b0;
            col_en   <= '0;
            row_n    <= '1;
            swap_ack <= 1'b0;
            fs_q     <= 1'b0;
            first    <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lit_len  <= lit_n;
            col      <= col_n;
            disp     <= disp_n;
            front    <= front ^ do_swap;
            pending  <= do_swap ? 1'b0 : (pending | swap_req);
            col_en   <= col_en_n;
            row_n    <= active ? ~fb[front][disp][col] : '1;
            swap_ack <= do_swap;
            fs_q     <= boundary;
            first    <= 1'b0;
        end
    end

    // Writes land in the pre-swap back bank, so a boundary-cycle write shows in the new frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int d = 0; d < N_DISP; d++)
                    for (int c = 0; c < N_COLS; c++)
                        fb[b][d][c] <= '0;
        end else if (wr_en && wr_ok) begin
            fb[~front][wr_disp][wr_col] <= wr_data;
        end
    end

    // The first frame after reset begins in the release cycle itself, before any edge.
    assign frame_start = fs_q | (first & reset);

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: per-cycle comparison against a timeline model
// of slot order, PWM window, banked frame store and boundary swap.
module tb_led_matrix_scanner;
    localparam int ND = 2, NC = 8, NR = 8, DW = 32, BL = 2;
    localparam int SLOT = DW + BL;
    localparam int FRAME = ND * NC * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [0:0]  wr_disp = '0;
    logic [2:0]  wr_col = '0;
    logic [7:0]  wr_data = '0;
    logic        swap_req = 1'b0;
    logic [3:0]  bright = 4'd15;
    logic [15:0] col_en;
    logic [7:0]  row_n;
    logic        swap_ack, frame_start;

    led_matrix_scanner #(.N_DISP(ND), .N_COLS(NC), .N_ROWS(NR), .DWELL(DW), .BLANK(BL)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_disp(wr_disp), .wr_col(wr_col),
        .wr_data(wr_data), .swap_req(swap_req), .bright(bright), .col_en(col_en),
        .row_n(row_n), .swap_ack(swap_ack), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int t = 0, lit = 0, acks = 0;
    logic [7:0] mem [2][2][8];
    logic mfront = 1'b0, mpend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0d)", tag, obs, exp, t);
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 8; c++)
                    mem[b][d][c] = '0;
        mfront = 1'b0; mpend = 1'b0; t = 0; lit = 0;
    endtask

    // One clock: predict outputs from the inputs the edge will see, then compare.
    task automatic tick();
        int r, k, q, c, d;
        logic [15:0] ec;
        logic [7:0]  er;
        logic        ef, sw;
        if (!reset) begin
            @(posedge clk); #1;
            model_clear();
            chk("rst_col_en", 32'(col_en), 32'h0);
            chk("rst_row_n", 32'(row_n), 32'hFF);
            chk("rst_swap_ack", 32'(swap_ack), 32'h0);
            chk("rst_frame_start", 32'(frame_start), 32'h0);
            return;
        end
        r = t % FRAME; k = r / SLOT; q = r % SLOT; c = k / ND; d = k % ND;
        ec = '0; er = 8'hFF;
        if (q >= BL && (q - BL) < lit) begin
            ec = 16'(1) << (d * NC + c);
            er = ~mem[mfront][d][c];
        end
        if (q == BL - 1) lit = (int'(bright) + 1) * DW / 16;
        ef = (r == FRAME - 1);
        sw = ef && (mpend || swap_req);
        if (wr_en) mem[~mfront][wr_disp][wr_col] = wr_data;
        if (sw) begin mfront = ~mfront; mpend = 1'b0; end
        else if (swap_req) mpend = 1'b1;
        @(posedge clk); #1;
        chk("col_en", 32'(col_en), 32'(ec));
        chk("row_n", 32'(row_n), 32'(er));
        chk("swap_ack", 32'(swap_ack), 32'(sw));
        chk("frame_start", 32'(frame_start), 32'(ef));
        if (swap_ack) acks++;
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
        #1;
        chk("fs_after_reset", 32'(frame_start), 32'h1);
        chk("ack_after_reset", 32'(swap_ack), 32'h0);
    endtask

    initial begin
        model_clear();
        // idle scan at full brightness, blank buffers
        do_reset(3);
        run(FRAME + 40);

        // write then swap: d0 c3 = A5 shows as 5A in slot (c3,d0)
        wr_en = 1'b1; wr_disp = 1'b0; wr_col = 3'd3; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0; swap_req = 1'b1;
        tick();
        swap_req = 1'b0; acks = 0;
        run(2 * FRAME);
        chk("acks_first_swap", 32'(acks), 32'd1);

        // PWM levels and a mid-slot brightness change
        bright = 4'd0; run(FRAME);
        bright = 4'd7; run(FRAME / 2);
        bright = 4'd0;
        while (t % SLOT != BL + 5) tick();
        bright = 4'd15;
        run(3 * SLOT);
        bright = 4'd15;

        // back-buffer writes without a swap stay invisible
        wr_en = 1'b1; wr_disp = 1'b1; wr_col = 3'd2; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0; acks = 0;
        run(3 * FRAME);
        chk("acks_no_swap", 32'(acks), 32'd0);

        // two requests in one frame give one swap
        while (t % FRAME != 10) tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        run(200);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        acks = 0;
        run(FRAME);
        chk("acks_double_req", 32'(acks), 32'd1);

        // swap request and write in the boundary cycle itself
        while (t % FRAME != FRAME - 1) tick();
        acks = 0;
        swap_req = 1'b1; wr_en = 1'b1; wr_disp = 1'b1; wr_col = 3'd7; wr_data = 8'h01;
        tick();
        swap_req = 1'b0; wr_en = 1'b0;
        run(FRAME + 5);
        chk("acks_boundary", 32'(acks), 32'd1);

        // reset in the middle of a lit DRIVE window
        while (t % SLOT != BL + 10) tick();
        chk("lit_before_reset", 32'($countones(col_en)), 32'd1);
        do_reset(2);
        run(FRAME + 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
